// File: rtl/serial_frame_tx_pkg.sv
// rtl/serial_frame_tx_pkg.sv - shared types and defaults for the serial frame tx/rx blocks
package serial_frame_tx_pkg;

  localparam int NT_W_DEF   = 8;
  localparam int BYTE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of parallel words needed to carry a frame of the given bit length.
  function automatic int bytes_for_bits(input int bits, input int byte_w);
    return (bits + byte_w - 1) / byte_w;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// rtl/serial_frame_tx_if.sv - frame request, byte handshake and serial output bundle
interface serial_frame_tx_if
  import serial_frame_tx_pkg::*;
#(
  parameter int NT_W   = NT_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
);

  logic              start;
  logic [NT_W-1:0]   nt;
  logic [BYTE_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              serOut;
  logic              en_out;
  logic              done;

  modport master (
    output start, nt, din, din_valid,
    input  din_ready, serOut, en_out, done
  );

  modport slave (
    input  start, nt, din, din_valid,
    output din_ready, serOut, en_out, done
  );

endinterface

// File: rtl/tx_bit_counter.sv
// rtl/tx_bit_counter.sv - loadable down counter of remaining frame bits
module tx_bit_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         last
);

  // Never wraps below zero, so a stray enable after the final bit is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign last = (value == W'(1));

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - shifts nt bits of a byte stream out LSB first, qualified by en_out
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int NT_W   = NT_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  serial_frame_tx_if.slave  bus
);

  localparam int BI_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  state_t            state;
  logic [BYTE_W-1:0] sh;
  logic [BYTE_W-1:0] sh_next;
  logic [BI_W-1:0]   bi;
  logic [NT_W-1:0]   rem;
  logic              rem_last;
  logic              cnt_load;
  logic              cnt_en;

  assign sh_next  = sh >> 1;
  assign cnt_load = (state == ST_IDLE) && bus.start && (bus.nt != '0);
  assign cnt_en   = (state == ST_SHIFT) && (rem != '0);

  tx_bit_counter #(.W(NT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (bus.nt),
    .en       (cnt_en),
    .value    (rem),
    .last     (rem_last)
  );

  // Outputs are computed alongside the next state so they are registered and
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sh            <= '0;
      bi            <= '0;
      bus.serOut    <= 1'b0;
      bus.en_out    <= 1'b0;
      bus.done      <= 1'b0;
      bus.din_ready <= 1'b0;
    end else begin
      bus.serOut    <= 1'b0;
      bus.en_out    <= 1'b0;
      bus.done      <= 1'b0;
      bus.din_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.nt != '0) begin
              state         <= ST_LOAD;
              bus.din_ready <= 1'b1;
            end else begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (bus.din_valid) begin
            state      <= ST_SHIFT;
            sh         <= bus.din;
            bi         <= '0;
            bus.en_out <= 1'b1;
            bus.serOut <= bus.din[0];
          end else begin
            bus.din_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          sh <= sh_next;
          bi <= bi + BI_W'(1);
          if (rem_last) begin
            // Unsent bits of the final byte are dropped here.
            state    <= ST_DONE;
            sh       <= '0;
            bus.done <= 1'b1;
          end else if (bi == BI_W'(BYTE_W - 1)) begin
            state         <= ST_LOAD;
            bus.din_ready <= 1'b1;
          end else begin
            bus.en_out <= 1'b1;
            bus.serOut <= sh_next[0];
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - randomized self-checking bench for serial_frame_tx
module tb_serial_frame_tx;
  import serial_frame_tx_pkg::*;

  localparam int NW = 8;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst;

  serial_frame_tx_if #(.NT_W(NW), .BYTE_W(BW)) bus();

  serial_frame_tx #(.NT_W(NW), .BYTE_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Observation counters and captured serial bits.
  bit   chk_on = 1'b0;
  int   en_cnt, hs_cnt, done_cnt, wait_cnt;
  logic got_bits[$];

  // Reference: frame progress in terms of bits sent / bits owed.
  bit   m_idle = 1'b1, m_wait = 1'b0, m_first = 1'b0, m_cont = 1'b0, m_done = 1'b0;
  int   m_nt = 0, m_sent = 0, m_pushed = 0;
  logic exp_q[$];

  always @(negedge clk) begin
    bit   exp_en, n_idle, n_wait, n_first, n_cont, n_done;
    logic b;
    if (chk_on) begin
      exp_en = m_first || m_cont;
      chk("din_ready", {255'd0, bus.din_ready}, {255'd0, m_wait});
      chk("en_out", {255'd0, bus.en_out}, {255'd0, exp_en});
      chk("done", {255'd0, bus.done}, {255'd0, m_done});
      if (!bus.en_out) chk("serOut_quiet", {255'd0, bus.serOut}, 256'd0);
      if (bus.en_out) begin
        got_bits.push_back(bus.serOut);
        en_cnt++;
      end
      if (bus.done) done_cnt++;
      if (bus.din_ready && bus.din_valid) hs_cnt++;
      if (bus.din_ready && !bus.din_valid) wait_cnt++;
      if (exp_en) begin
        if (exp_q.size() == 0) begin
          chk("model_bits_left", 256'd0, 256'd1);
        end else begin
          b = exp_q.pop_front();
          chk("serOut", {255'd0, bus.serOut}, {255'd0, b});
        end
        m_sent++;
      end
      n_done  = exp_en && (m_sent == m_nt);
      n_cont  = exp_en && (m_sent < m_nt) && ((m_sent % BW) != 0);
      n_wait  = (m_wait && !bus.din_valid) || (exp_en && (m_sent < m_nt) && ((m_sent % BW) == 0));
      n_first = m_wait && bus.din_valid;
      n_idle  = m_idle || m_done;
      if (n_first) begin
        for (int i = 0; i < BW; i++) begin
          if (m_pushed < m_nt) begin
            exp_q.push_back(bus.din[i]);
            m_pushed++;
          end
        end
      end
      if (m_idle && bus.start) begin
        n_idle   = 1'b0;
        m_nt     = int'(bus.nt);
        m_sent   = 0;
        m_pushed = 0;
        if (bus.nt == '0) n_done = 1'b1;
        else              n_wait = 1'b1;
      end
      if (rst) begin
        n_idle = 1'b1; n_wait = 1'b0; n_first = 1'b0; n_cont = 1'b0; n_done = 1'b0;
        exp_q.delete();
      end
      m_idle = n_idle; m_wait = n_wait; m_first = n_first; m_cont = n_cont; m_done = n_done;
    end
  end

  // Byte source: queue of bytes, optional stall counted only while din_ready is high.
  logic [7:0] src_q[$];
  int         stall = 0;
  bit         rand_stall = 1'b0;

  task automatic set_src(input logic [7:0] q[$], input int s);
    src_q = q;
    stall = s;
    bus.din_valid = (src_q.size() > 0) && (stall == 0);
    bus.din = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  task automatic tick();
    logic s_hs, s_rdy;
    @(negedge clk);
    s_hs  = bus.din_ready && bus.din_valid;
    s_rdy = bus.din_ready;
    @(posedge clk);
    #1;
    if (s_hs === 1'b1) begin
      void'(src_q.pop_front());
      if (rand_stall) stall = $urandom_range(0, 3);
    end else if (s_rdy === 1'b1 && stall > 0) begin
      stall--;
    end
    bus.din_valid = (src_q.size() > 0) && (stall == 0);
    bus.din = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
  endtask

  task automatic clear_counters();
    en_cnt = 0; hs_cnt = 0; done_cnt = 0; wait_cnt = 0;
    got_bits.delete();
  endtask

  task automatic wait_done(input int limit, input bit noise);
    for (int i = 0; i < limit && done_cnt == 0; i++) begin
      if (noise) begin
        bus.start = ($urandom_range(0, 5) == 0);
        bus.nt    = 8'($urandom);
      end
      tick();
    end
    bus.start = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 256'd0, 256'd1);
  endtask

  function automatic logic [255:0] got_vec();
    logic [255:0] v = '0;
    for (int i = 0; i < got_bits.size() && i < 256; i++) v[i] = got_bits[i];
    return v;
  endfunction

  task automatic run_frame(input int n, input logic [7:0] bytes[$], input int stall0,
                           input bit noise, input string tag);
    logic [255:0] e;
    clear_counters();
    set_src(bytes, stall0);
    bus.start = 1'b1;
    bus.nt    = 8'(n);
    tick();
    bus.start = 1'b0;
    bus.nt    = 8'($urandom);
    wait_done(n * 4 + 200, noise);
    e = '0;
    for (int i = 0; i < n; i++) e[i] = bytes[i / BW][i % BW];
    chk({tag, "_bits"}, got_vec(), e);
    chk({tag, "_en_cnt"}, 256'(en_cnt), 256'(n));
    chk({tag, "_done_cnt"}, 256'(done_cnt), 256'd1);
    chk({tag, "_handshakes"}, 256'(hs_cnt), 256'((n + BW - 1) / BW));
    src_q.delete();
    bus.din_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.nt = '0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    tick();
    chk_on = 1'b1;
    chk("reset_din_ready", {255'd0, bus.din_ready}, 256'd0);
    chk("reset_en_out", {255'd0, bus.en_out}, 256'd0);
    chk("reset_serOut", {255'd0, bus.serOut}, 256'd0);
    chk("reset_done", {255'd0, bus.done}, 256'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single byte, data ready immediately.
    q = '{8'hA5};
    run_frame(8, q, 0, 1'b0, "a5");
    chk("a5_literal", got_vec(), 256'hA5);

    // Partial second byte; upper bits of FF never go out.
    q = '{8'h3C, 8'hFF};
    run_frame(12, q, 0, 1'b0, "nt12");
    chk("nt12_literal", got_vec(), 256'hF3C);

    // Empty frame.
    clear_counters();
    bus.start = 1'b1;
    bus.nt = 8'd0;
    tick();
    bus.start = 1'b0;
    wait_done(10, 1'b0);
    chk("nt0_en_cnt", 256'(en_cnt), 256'd0);
    chk("nt0_handshakes", 256'(hs_cnt), 256'd0);
    chk("nt0_done_cnt", 256'(done_cnt), 256'd1);

    // Source withholds the first byte for 5 LOAD cycles.
    q = '{8'h5A, 8'hC3};
    run_frame(16, q, 5, 1'b0, "stall");
    chk("stall_literal", got_vec(), 256'hC35A);
    chk("stall_wait_cycles", 256'(wait_cnt), 256'd5);

    // Longest frame with stray start pulses throughout.
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(8'h81);
    run_frame(255, q, 0, 1'b1, "max");
    chk("max_en_literal", 256'(en_cnt), 256'd255);

    // Abort mid-frame.
    clear_counters();
    q = '{8'hE7, 8'h18, 8'h99};
    set_src(q, 0);
    bus.start = 1'b1;
    bus.nt = 8'd20;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 50 && got_bits.size() < 3; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_din_ready", {255'd0, bus.din_ready}, 256'd0);
    chk("abort_en_out", {255'd0, bus.en_out}, 256'd0);
    chk("abort_serOut", {255'd0, bus.serOut}, 256'd0);
    chk("abort_done", {255'd0, bus.done}, 256'd0);
    rst = 1'b0;
    src_q.delete();
    bus.din_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_done", 256'(done_cnt), 256'd0);
    chk("abort_bits_sent", 256'(en_cnt), 256'd4);
    q = '{8'h6E};
    run_frame(8, q, 0, 1'b0, "after_abort");
    chk("after_abort_literal", got_vec(), 256'h6E);

    // Randomized frames with random source stalls.
    rand_stall = 1'b1;
    for (int f = 0; f < 20; f++) begin
      n = (f == 0) ? 255 : $urandom_range(1, 40);
      q.delete();
      for (int i = 0; i < (n + BW - 1) / BW; i++) q.push_back(8'($urandom));
      run_frame(n, q, $urandom_range(0, 3), f[0], "rand");
    end
    rand_stall = 1'b0;

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Transmit end of the team's serial transfer path. Accepts a bit count `nt` and a stream of parallel bytes over a valid/ready handshake. Shifts exactly `nt` bits out on `serOut`, LSB first within each byte, qualified by `en_out`. Pulses `done` after the last bit. It drives the serial input and enable of the downstream serial transfer/counter stage, which gates its own bit counting on `en_out`.

## Interface
- `NT_W`, default 8: width of the bit-count input.
- `BYTE_W`, default 8: width of the parallel data word.

Ports:
- `clk` input, 1 bit: single clock, all state on posedge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begin a frame; sampled only in IDLE.
- `nt` input, `NT_W` bits: number of bits in the frame; latched on accepted `start`.
- `din` input, `BYTE_W` bits: next data byte.
- `din_valid` input, 1 bit: `din` holds a byte.
- `din_ready` output, 1 bit: block will accept `din` this cycle.
- `serOut` output, 1 bit: serial data; 0 whenever `en_out` = 0.
- `en_out` output, 1 bit: `serOut` carries a valid frame bit this cycle.
- `done` output, 1 bit: one-cycle pulse, frame finished.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. All outputs are registered, Moore-style, decoded from state and registers.
- IDLE
  - `start`=1 and `nt`≠0: latch `nt` into remaining counter `rem`, go to LOAD.
  - `start`=1 and `nt`=0: go to DONE directly; no bits are sent.
- LOAD
  - `din_ready`=1.
  - On `din_valid`: capture `din` into shift register `sh`, clear bit index `bi`, go to SHIFT.
  - Otherwise stay in LOAD (bubble); `en_out`=0.
- SHIFT
  - `serOut`=`sh[0]`, `en_out`=1.
  - Each cycle: `sh` shifts right by 1, `rem` decrements, `bi` increments.
  - `rem`=1 (last bit this cycle): go to DONE.
  - Otherwise, `bi`=`BYTE_W`-1 (last bit of byte): go to LOAD.
  - Otherwise stay in SHIFT.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Width rules:
  - `rem` is `NT_W` bits and never wraps; decrement happens only in SHIFT with `rem`≥1.
  - Maximum frame is 2^`NT_W`-1 bits, i.e. 255 bits, which spans 32 bytes.
  - Bits of the final byte beyond `rem` are discarded.
- `start` is ignored outside IDLE; `nt` changes after latch have no effect.
- `din_valid` is ignored outside LOAD; `din_ready` is 0 outside LOAD.
- Reset, at any time including mid-frame:
  - Next state is IDLE; `serOut`, `en_out`, `done`, `din_ready` are 0.
  - `rem`, `bi`, `sh` are cleared; the partial byte is discarded.
  - No `done` pulse is produced for the aborted frame.

## Timing
- `start` accepted at cycle t: `din_ready`=1 from t+1.
- Byte handshake at cycle u: first bit on `serOut`/`en_out` at u+1.
- Byte boundary: one bubble minimum between consecutive bytes.
  - Last bit of a byte is at cycle v; `din_ready` rises at v+1; next bit appears at the earliest at v+2.
  - `en_out`=0 during bubbles; the downstream stage must count only `en_out` cycles.
- Last frame bit at cycle w: `done`=1 at w+1, IDLE at w+2. A new `start` is accepted at w+2.
- `nt`=0 with `start` at t: `done`=1 at t+1; `en_out` stays 0.
- Reset asserted at cycle r: all outputs are 0 at r+1.

## Structure
- Shared package:
  - State encoding constants (IDLE, LOAD, SHIFT, DONE).
  - `NT_W`, `BYTE_W` defaults.
  - This package is also used by the receive-side block.
- One sub-module: `tx_bit_counter`.
  - Loadable `NT_W`-bit down counter with enable.
  - `last` flag asserted when the value is 1.
  - Synchronous active-high reset.
- The FSM, shift register and byte index stay in the top module.

## Test plan
- `nt`=8, `din`=8'hA5 presented immediately.
  - Required: `serOut`=1,0,1,0,0,1,0,1 on 8 consecutive `en_out` cycles starting 1 cycle after the handshake.
  - Required: `done` one cycle after the last bit.
- `nt`=12, bytes 8'h3C then 8'hFF, `din_valid` held high.
  - Required: 8 bits of 3C, then one bubble with `en_out`=0, then 4 ones.
  - Required: `done` pulse; upper 4 bits of FF are never driven.
- `nt`=0, `start`=1.
  - Required: `done`=1 the next cycle; `din_ready` and `en_out` stay 0.
- `nt`=16, `din_valid` withheld for 5 cycles in LOAD.
  - Required: `din_ready` stays 1 and `en_out` stays 0 for those cycles.
  - Required: transmission resumes 1 cycle after the handshake.
- `nt`=255, all bytes 8'h81.
  - Required: exactly 255 `en_out` cycles and 32 handshakes.
  - Required: `done` once; `start` pulses during the frame are ignored.
- Reset asserted mid-frame, after 3 bits of `nt`=20.
  - Required: next cycle all outputs are 0 and the state is IDLE, with no `done` pulse.
  - Required: a following `start` with `nt`=8 runs cleanly.
